// File: rtl/retire_stats_pkg.sv
// Shared definitions for the retire statistics unit: counter indices and the
// run/halt state encoding.
package stats_pkg;

  localparam int NUM_CNT        = 8;
  localparam int CNT_CYCLES     = 0;
  localparam int CNT_INST       = 1;
  localparam int CNT_ICACHE_REQ = 2;
  localparam int CNT_ICACHE_HIT = 3;
  localparam int CNT_DCACHE_REQ = 4;
  localparam int CNT_DCACHE_HIT = 5;
  localparam int CNT_HALT_CYCLE = 6;
  localparam int CNT_PROTO_ERR  = 7;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } stats_state_e;

endpackage

// File: rtl/retire_stats_if.sv
// Event/read bundle between the MEM/WB stage (master) and the statistics
// unit (slave). Events are plain per-cycle strobes sampled every rising edge;
// there is no valid/ready handshake, and nothing is ever back-pressured.
interface retire_stats_if #(
  parameter int CNT_W = 32
);
  import stats_pkg::*;

  logic             clr;
  logic             ret_regwrite;
  logic             ret_memwrite;
  logic             ret_halt;
  logic             icache_req;
  logic             icache_hit;
  logic             dcache_req;
  logic             dcache_hit;
  logic [2:0]       rd_sel;
  logic [CNT_W-1:0] rd_data;
  logic             halted;
  stats_state_e     state;

  modport master (
    output clr, ret_regwrite, ret_memwrite, ret_halt,
    output icache_req, icache_hit, dcache_req, dcache_hit, rd_sel,
    input  rd_data, halted, state
  );

  modport slave (
    input  clr, ret_regwrite, ret_memwrite, ret_halt,
    input  icache_req, icache_hit, dcache_req, dcache_hit, rd_sel,
    output rd_data, halted, state
  );

endinterface

// File: rtl/retire_stats_sat_counter.sv
// Saturating counter with synchronous clear and parallel load.
// Priority: clr, then load, then inc; the count sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] din,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/retire_stats.sv
// Retire/cache statistics unit: counts events while RUN, freezes on halt
// retirement, and exposes the counters through a registered 8:1 read port.
module retire_stats
  import stats_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  retire_stats_if.slave  bus
);

  stats_state_e     state;
  stats_state_e     nextState;
  logic             running;
  logic [NUM_CNT-1:0] incVec;
  logic [NUM_CNT-1:0] loadVec;
  logic [CNT_W-1:0] cnt [NUM_CNT];
  logic [CNT_W-1:0] cyclesNext;
  logic [CNT_W-1:0] rdData;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= nextState;
    end
  end

  // clr wins over a same-cycle halt; HALTED ignores every event.
  always_comb begin
    nextState = state;
    if (bus.clr) begin
      nextState = RUN;
    end else if ((state == RUN) && bus.ret_halt) begin
      nextState = HALTED;
    end
  end

  assign running = (state == RUN) && !bus.clr;

  always_comb begin
    incVec                 = '0;
    incVec[CNT_CYCLES]     = running;
    incVec[CNT_INST]       = running & (bus.ret_halt | bus.ret_regwrite | bus.ret_memwrite);
    incVec[CNT_ICACHE_REQ] = running & bus.icache_req;
    incVec[CNT_ICACHE_HIT] = running & bus.icache_hit;
    incVec[CNT_DCACHE_REQ] = running & bus.dcache_req;
    incVec[CNT_DCACHE_HIT] = running & bus.dcache_hit;
    incVec[CNT_PROTO_ERR]  = running & ((bus.icache_hit & ~bus.icache_req) |
                                        (bus.dcache_hit & ~bus.dcache_req));
    loadVec                 = '0;
    loadVec[CNT_HALT_CYCLE] = running & bus.ret_halt;
  end

  // halt_cycle captures the cycle count including the halt's own cycle.
  assign cyclesNext = (cnt[CNT_CYCLES] == {CNT_W{1'b1}}) ? cnt[CNT_CYCLES]
                                                         : cnt[CNT_CYCLES] + CNT_W'(1);

  for (genvar i = 0; i < NUM_CNT; i++) begin : gCnt
    sat_counter #(.W(CNT_W)) uCnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (bus.clr),
      .inc  (incVec[i]),
      .load (loadVec[i]),
      .din  (cyclesNext),
      .q    (cnt[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdData <= '0;
    end else begin
      rdData <= cnt[bus.rd_sel];
    end
  end

  assign bus.rd_data = rdData;
  assign bus.halted  = (state == HALTED);
  assign bus.state   = state;

endmodule

// File: tb/tb_retire_stats.sv
// Directed bench for retire_stats: a 32-bit unit for the functional sequences
// and a 4-bit unit for saturation and asynchronous reset.
module tb_retire_stats;
  import stats_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rst2;

  always #5 clk = ~clk;

  retire_stats_if #(.CNT_W(32)) bus  ();
  retire_stats_if #(.CNT_W(4))  sbus ();

  retire_stats #(.CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  retire_stats #(.CNT_W(4)) dut4 (
    .clk (clk),
    .rst (rst2),
    .bus (sbus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] expv;
    string       name;
  } rd_vec_t;

  rd_vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ev(input logic rw, input logic mw, input logic h,
                        input logic ir, input logic ih, input logic dr, input logic dh);
    bus.ret_regwrite = rw;
    bus.ret_memwrite = mw;
    bus.ret_halt     = h;
    bus.icache_req   = ir;
    bus.icache_hit   = ih;
    bus.dcache_req   = dr;
    bus.dcache_hit   = dh;
  endtask

  task automatic read_table();
    for (int i = 0; i < 8; i++) begin
      bus.rd_sel = tbl[i].sel;
      exp_q.push_back(tbl[i].expv);
      tick(1);
      check(tbl[i].name, bus.rd_data, exp_q.pop_front());
    end
  endtask

  initial begin
    logic [7:0] rwPat;
    logic [7:0] mwPat;

    // Expected counters after the event run and halt at cycle 20.
    tbl[0] = '{3'd0, 32'd20, "halt_cycles"};
    tbl[1] = '{3'd1, 32'd8,  "halt_inst"};
    tbl[2] = '{3'd2, 32'd4,  "halt_icache_req"};
    tbl[3] = '{3'd3, 32'd6,  "halt_icache_hit"};
    tbl[4] = '{3'd4, 32'd5,  "halt_dcache_req"};
    tbl[5] = '{3'd5, 32'd3,  "halt_dcache_hit"};
    tbl[6] = '{3'd6, 32'd20, "halt_halt_cycle"};
    tbl[7] = '{3'd7, 32'd2,  "halt_proto_err"};

    rwPat = 8'h57;
    mwPat = 8'hA4;

    rst  = 1'b1;
    rst2 = 1'b1;
    bus.clr = 1'b0;
    bus.rd_sel = 3'd0;
    set_ev(0, 0, 0, 0, 0, 0, 0);
    sbus.clr = 1'b0;
    sbus.ret_regwrite = 1'b0;
    sbus.ret_memwrite = 1'b0;
    sbus.ret_halt = 1'b0;
    sbus.icache_req = 1'b0;
    sbus.icache_hit = 1'b0;
    sbus.dcache_req = 1'b0;
    sbus.dcache_hit = 1'b0;
    sbus.rd_sel = 3'd0;

    tick(2);
    check("reset_rd_data", bus.rd_data, 32'd0);
    check("reset_halted", {31'd0, bus.halted}, 32'd0);
    check("reset_state", 32'(bus.state), 32'(RUN));

    // Ten idle cycles, then one more edge to register the read.
    rst = 1'b0;
    tick(11);
    check("idle_cycles", bus.rd_data, 32'd10);
    check("idle_halted", {31'd0, bus.halted}, 32'd0);
    for (int i = 1; i < 8; i++) begin
      bus.rd_sel = 3'(i);
      tick(1);
      check($sformatf("idle_idx%0d", i), bus.rd_data, 32'd0);
    end

    bus.clr = 1'b1;
    tick(1);
    bus.clr = 1'b0;

    // 19 event cycles, then halt on cycle 20.
    for (int i = 0; i < 8; i++) begin
      set_ev(rwPat[i], mwPat[i], 0, 0, 0, 0, 0);
      tick(1);
    end
    set_ev(0, 0, 0, 1, 1, 0, 0); tick(4);
    set_ev(0, 0, 0, 0, 1, 0, 0); tick(2);
    set_ev(0, 0, 0, 0, 0, 1, 1); tick(3);
    set_ev(0, 0, 0, 0, 0, 1, 0); tick(2);
    set_ev(0, 0, 1, 0, 0, 0, 0); tick(1);
    check("halt_rises", {31'd0, bus.halted}, 32'd1);
    check("halt_state", 32'(bus.state), 32'(HALTED));

    // Everything held high while halted must be ignored.
    set_ev(1, 1, 1, 1, 1, 1, 1);
    tick(10);
    check("halt_held", {31'd0, bus.halted}, 32'd1);
    read_table();

    // clr with halt while HALTED: clears and returns to RUN.
    bus.clr = 1'b1;
    bus.rd_sel = 3'd0;
    tick(1);
    bus.clr = 1'b0;
    set_ev(0, 0, 0, 0, 0, 0, 0);
    check("clr_halted", {31'd0, bus.halted}, 32'd0);
    tick(1);
    check("clr_cycles", bus.rd_data, 32'd0);
    for (int i = 1; i < 8; i++) begin
      bus.rd_sel = 3'(i);
      tick(1);
      check($sformatf("clr_idx%0d", i), bus.rd_data, 32'd0);
    end
    bus.rd_sel = 3'd0;
    tick(1);
    check("clr_counting", bus.rd_data, 32'd8);

    // clr beats ret_halt in RUN as well.
    bus.clr = 1'b1;
    bus.ret_halt = 1'b1;
    bus.rd_sel = 3'd6;
    tick(1);
    bus.clr = 1'b0;
    set_ev(0, 0, 0, 0, 0, 0, 0);
    check("clr_prio_halted", {31'd0, bus.halted}, 32'd0);
    tick(1);
    check("clr_prio_halt_cycle", bus.rd_data, 32'd0);

    // 4-bit unit: saturation at 15.
    sbus.ret_regwrite = 1'b1;
    sbus.rd_sel = 3'd0;
    rst2 = 1'b0;
    tick(20);
    check("sat_cycles", {28'd0, sbus.rd_data}, 32'd15);
    sbus.rd_sel = 3'd1;
    tick(1);
    check("sat_inst", {28'd0, sbus.rd_data}, 32'd15);
    sbus.ret_halt = 1'b1;
    tick(1);
    check("sat_halted", {31'd0, sbus.halted}, 32'd1);
    sbus.ret_halt = 1'b0;
    sbus.rd_sel = 3'd6;
    tick(1);
    check("sat_halt_cycle", {28'd0, sbus.rd_data}, 32'd15);

    // Asynchronous reset between edges.
    #2 rst2 = 1'b1;
    #1;
    check("async_rst_rd_data", {28'd0, sbus.rd_data}, 32'd0);
    check("async_rst_halted", {31'd0, sbus.halted}, 32'd0);
    tick(1);
    sbus.ret_regwrite = 1'b0;
    sbus.rd_sel = 3'd0;
    rst2 = 1'b0;
    tick(4);
    check("post_rst_cycles", {28'd0, sbus.rd_data}, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
